// File: rtl/oam_dma_ctrl.sv
// FF46 OAM DMA engine: copies 160 bytes from {FF46, 8'h00} into OAM and owns
// the shared memory bus while the copy runs; otherwise the CPU passes through.
module oam_dma_ctrl #(
  parameter int CYCLES_PER_BYTE = 4,
  parameter int START_DELAY     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] CPU_ADDR,
  input  logic        CPU_WR,
  input  logic        CPU_RD,
  input  logic [7:0]  CPU_DATA_out,
  output logic [7:0]  CPU_DATA_in,
  output logic [7:0]  REG_DATA,
  output logic [15:0] MEM_ADDR,
  output logic        MEM_RD,
  output logic        MEM_WR,
  output logic [7:0]  MEM_WDATA,
  input  logic [7:0]  MEM_RDATA,
  output logic        OAM_WR,
  output logic [7:0]  OAM_ADDR,
  output logic [7:0]  OAM_WDATA,
  output logic        DMA_ACTIVE
);

  localparam int SUB_W  = $clog2(CYCLES_PER_BYTE);
  localparam int WAIT_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CYCLES_PER_BYTE - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(START_DELAY - 1);
  localparam logic [7:0]        IDX_LAST  = 8'd159;
  localparam logic [15:0]       BLOCK_END = 16'hFEA0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } state_t;

  state_t             state_r;
  logic [7:0]         ff46_r;
  logic [7:0]         idx_r;
  logic [SUB_W-1:0]   sub_r;
  logic [WAIT_W-1:0]  wait_r;
  logic               oam_wr_r;
  logic               dma_active_r;
  logic               ff46_wr_s;
  logic [7:0]         src_hi_s;

  assign ff46_wr_s = CPU_WR && (CPU_ADDR == 16'hFF46);

  // Source page: E0-FF is the echo mirror of C0-DF.
  always_comb begin
    if (ff46_r >= 8'hE0) begin
      src_hi_s = ff46_r - 8'h20;
    end else begin
      src_hi_s = ff46_r;
    end
  end

  // Transfer sequencer; an FF46 write restarts from any state and beats every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      ff46_r       <= 8'h00;
      idx_r        <= 8'd0;
      sub_r        <= SUB_W'(0);
      wait_r       <= WAIT_W'(0);
      oam_wr_r     <= 1'b0;
      dma_active_r <= 1'b0;
    end else if (ff46_wr_s) begin
      state_r      <= START;
      ff46_r       <= CPU_DATA_out;
      idx_r        <= 8'd0;
      sub_r        <= SUB_W'(0);
      wait_r       <= WAIT_W'(0);
      oam_wr_r     <= 1'b0;
      dma_active_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          oam_wr_r     <= 1'b0;
          dma_active_r <= 1'b0;
        end
        START: begin
          oam_wr_r <= 1'b0;
          if (wait_r == WAIT_LAST) begin
            state_r <= XFER;
            sub_r   <= SUB_W'(0);
          end else begin
            wait_r <= wait_r + WAIT_W'(1);
          end
        end
        XFER: begin
          // Read data arrives one clock after the sub==0 read, so OAM is written at sub==1.
          oam_wr_r <= (sub_r == SUB_W'(0));
          if (sub_r == SUB_LAST) begin
            sub_r <= SUB_W'(0);
            if (idx_r == IDX_LAST) begin
              state_r      <= IDLE;
              idx_r        <= 8'd0;
              dma_active_r <= 1'b0;
            end else begin
              idx_r <= idx_r + 8'd1;
            end
          end else begin
            sub_r <= sub_r + SUB_W'(1);
          end
        end
        default: begin
          state_r      <= IDLE;
          oam_wr_r     <= 1'b0;
          dma_active_r <= 1'b0;
        end
      endcase
    end
  end

  // Bus mux: DMA owns the bus in XFER and blinds the CPU below FEA0.
  always_comb begin
    MEM_ADDR    = CPU_ADDR;
    MEM_RD      = CPU_RD;
    MEM_WR      = CPU_WR;
    MEM_WDATA   = CPU_DATA_out;
    CPU_DATA_in = MEM_RDATA;
    if (state_r == XFER) begin
      MEM_ADDR  = {src_hi_s, idx_r};
      MEM_RD    = (sub_r == SUB_W'(0));
      MEM_WR    = 1'b0;
      MEM_WDATA = 8'h00;
      if (CPU_ADDR < BLOCK_END) begin
        CPU_DATA_in = 8'hFF;
      end else begin
        CPU_DATA_in = MEM_RDATA;
      end
    end else begin
      MEM_ADDR    = CPU_ADDR;
      MEM_RD      = CPU_RD;
      MEM_WR      = CPU_WR;
      MEM_WDATA   = CPU_DATA_out;
      CPU_DATA_in = MEM_RDATA;
    end
  end

  assign OAM_WR     = oam_wr_r;
  assign OAM_ADDR   = idx_r;
  assign OAM_WDATA  = MEM_RDATA;
  assign REG_DATA   = ff46_r;
  assign DMA_ACTIVE = dma_active_r;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized bench for oam_dma_ctrl: a synchronous memory model plus a
// transfer-level reference (byte i lands in OAM[i] at a fixed clock offset).
module tb_oam_dma_ctrl;

  localparam int CPB       = 4;
  localparam int SD        = 4;
  localparam int NBYTES    = 160;
  localparam int XFER_CLKS = SD + NBYTES * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_wr = 1'b0;
  logic        cpu_rd = 1'b0;
  logic [7:0]  cpu_data_out = 8'h00;
  logic [7:0]  cpu_data_in;
  logic [7:0]  reg_data;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        oam_wr;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        dma_active;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;

  ev_t        pq[$];
  ev_t        rdq[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         bad_wr = 0;
  int         wr_cyc = 0;
  logic [7:0] cur_src = 8'h00;
  logic [7:0] seed = 8'h00;

  oam_dma_ctrl #(.CYCLES_PER_BYTE(CPB), .START_DELAY(SD)) dut (
    .clk(clk), .rst(rst),
    .CPU_ADDR(cpu_addr), .CPU_WR(cpu_wr), .CPU_RD(cpu_rd),
    .CPU_DATA_out(cpu_data_out), .CPU_DATA_in(cpu_data_in), .REG_DATA(reg_data),
    .MEM_ADDR(mem_addr), .MEM_RD(mem_rd), .MEM_WR(mem_wr), .MEM_WDATA(mem_wdata),
    .MEM_RDATA(mem_rdata), .OAM_WR(oam_wr), .OAM_ADDR(oam_addr),
    .OAM_WDATA(oam_wdata), .DMA_ACTIVE(dma_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory content: C1xx holds i^5A, every other address a seeded hash.
  function automatic logic [7:0] mem_val(input logic [15:0] a);
    logic [7:0] hi;
    logic [7:0] lo;
    hi = a[15:8];
    lo = a[7:0];
    if (hi == 8'hC1) begin
      return lo ^ 8'h5A;
    end else begin
      return (hi * 8'd29) ^ (lo * 8'd11 + 8'd7) ^ seed;
    end
  endfunction

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem_val(mem_addr);
  end

  always @(negedge clk) begin
    #3;
    if (oam_wr) pq.push_back('{cyc, {8'h00, oam_addr}, oam_wdata});
    if (dma_active && mem_rd) rdq.push_back('{cyc, mem_addr, 8'h00});
    if (dma_active && mem_wr) bad_wr++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_bus();
    cpu_wr = 1'b0;
    cpu_rd = 1'b0;
  endtask

  function automatic int n_pulses();
    int n = 0;
    foreach (pq[i]) if (pq[i].cyc >= wr_cyc) n++;
    return n;
  endfunction

  task automatic write_ff46(input logic [7:0] v);
    cpu_addr     = 16'hFF46;
    cpu_data_out = v;
    cpu_wr       = 1'b1;
    cpu_rd       = 1'b0;
    wr_cyc       = cyc + 1;
    if (v >= 8'd224) cur_src = v - 8'd32;
    else cur_src = v;
    step();
    cpu_wr   = 1'b0;
    cpu_addr = 16'h0000;
    check_val("reg_data", 32'(reg_data), 32'(v));
    check_val("dma_active_start", 32'(dma_active), 32'd1);
  endtask

  task automatic wait_k(input int k);
    while (cyc < wr_cyc + k) step();
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (dma_active === 1'b1 && n < 2 * XFER_CLKS) begin
      step();
      n++;
    end
    check_val({tag, " done_clk"}, 32'(cyc - wr_cyc), 32'(XFER_CLKS));
  endtask

  task automatic check_pulses(input string tag);
    int np = 0;
    int nr = 0;
    foreach (pq[i]) begin
      if (pq[i].cyc >= wr_cyc) begin
        check_val($sformatf("%s oam_clk[%0d]", tag, np), 32'(pq[i].cyc - wr_cyc), 32'(SD + CPB * np + 1));
        check_val($sformatf("%s oam_addr[%0d]", tag, np), 32'(pq[i].addr), 32'(np));
        check_val($sformatf("%s oam_data[%0d]", tag, np), 32'(pq[i].data),
                  32'(mem_val({cur_src, 8'(np)})));
        np++;
      end
    end
    foreach (rdq[i]) begin
      if (rdq[i].cyc >= wr_cyc) begin
        check_val($sformatf("%s rd_clk[%0d]", tag, nr), 32'(rdq[i].cyc - wr_cyc), 32'(SD + CPB * nr));
        check_val($sformatf("%s rd_addr[%0d]", tag, nr), 32'(rdq[i].addr), 32'({cur_src, 8'(nr)}));
        nr++;
      end
    end
    check_val({tag, " oam_count"}, 32'(np), 32'(NBYTES));
    check_val({tag, " rd_count"}, 32'(nr), 32'(NBYTES));
  endtask

  task automatic cpu_traffic(input int n, input bit io_only);
    logic [15:0] a;
    for (int j = 0; j < n; j++) begin
      if (io_only) begin
        a = 16'($urandom_range(16'hFF00, 16'hFFFF));
        if (a == 16'hFF46) a = 16'hFF47;
      end else if (j == 0) begin
        a = 16'hC000;
      end else if (j == 1) begin
        a = 16'h8000;
      end else begin
        a = 16'($urandom_range(0, 16'hFE9F));
      end
      cpu_addr     = a;
      cpu_data_out = 8'($urandom);
      if (j % 2 == 1) begin
        cpu_wr = 1'b1;
        cpu_rd = 1'b0;
        #1;
        check_val("xfer mem_wr", 32'(mem_wr), 32'd0);
      end else begin
        cpu_wr = 1'b0;
        cpu_rd = 1'b1;
        #1;
        if (!io_only) check_val("xfer blocked_rd", 32'(cpu_data_in), 32'hFF);
      end
      step();
    end
    idle_bus();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    seed = 8'($urandom);
    rst  = 1'b1;
    idle_bus();
    repeat (3) step();
    check_val("rst dma_active", 32'(dma_active), 32'd0);
    check_val("rst oam_wr", 32'(oam_wr), 32'd0);
    check_val("rst reg_data", 32'(reg_data), 32'd0);
    rst          = 1'b0;
    cpu_addr     = 16'h1234;
    cpu_data_out = 8'hA5;
    cpu_wr       = 1'b1;
    #1;
    check_val("idle mem_addr", 32'(mem_addr), 32'h1234);
    check_val("idle mem_wr", 32'(mem_wr), 32'd1);
    check_val("idle mem_wdata", 32'(mem_wdata), 32'hA5);
    idle_bus();
    step();

    // Plain transfer from C1.
    write_ff46(8'hC1);
    wait_done("t1");
    check_pulses("t1");
    check_val("t1 reg_data", 32'(reg_data), 32'hC1);

    // CPU traffic during the transfer, then passthrough once idle.
    step();
    write_ff46(8'($urandom_range(0, 8'hDF)));
    wait_k(SD + 4);
    cpu_traffic(40, 1'b0);
    wait_done("t2");
    check_pulses("t2");
    check_val("t2 bad_wr", 32'(bad_wr), 32'd0);
    cpu_addr = 16'hC000;
    cpu_rd   = 1'b1;
    #1;
    check_val("t2 idle mem_addr", 32'(mem_addr), 32'hC000);
    check_val("t2 idle mem_rd", 32'(mem_rd), 32'd1);
    step();
    check_val("t2 idle rdata", 32'(cpu_data_in), 32'(mem_val(16'hC000)));
    idle_bus();

    // Echo page.
    step();
    write_ff46(8'hE2);
    wait_done("t3");
    check_pulses("t3");

    // Restart at idx 80.
    step();
    write_ff46(8'hC0);
    wait_k(SD + 80 * CPB);
    check_val("t4 pre_restart", 32'(n_pulses()), 32'd80);
    write_ff46(8'hD0);
    wait_done("t4");
    check_pulses("t4");

    // Reset at idx 37, sub 0.
    step();
    write_ff46(8'($urandom));
    wait_k(SD + 37 * CPB);
    rst      = 1'b1;
    cpu_addr = 16'hC000;
    cpu_rd   = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_val("t5 dma_active", 32'(dma_active), 32'd0);
    check_val("t5 reg_data", 32'(reg_data), 32'd0);
    check_val("t5 oam_wr", 32'(oam_wr), 32'd0);
    check_val("t5 mem_addr", 32'(mem_addr), 32'hC000);
    check_val("t5 mem_rd", 32'(mem_rd), 32'd1);
    idle_bus();
    repeat (8) step();
    check_val("t5 pulses", 32'(n_pulses()), 32'd37);
    check_val("t5 idle", 32'(dma_active), 32'd0);

    // Restart on the very last clock of a transfer.
    step();
    write_ff46(8'hC1);
    wait_k(XFER_CLKS - 1);
    check_pulses("t6a");
    write_ff46(8'($urandom));
    wait_done("t6b");
    check_pulses("t6b");

    // Random pages with random CPU traffic.
    for (int r = 0; r < 3; r++) begin
      step();
      v = 8'($urandom);
      write_ff46(v);
      wait_k(SD + 8);
      cpu_traffic(30, r[0]);
      wait_done($sformatf("rnd%0d", r));
      check_pulses($sformatf("rnd%0d", r));
    end
    check_val("final bad_wr", 32'(bad_wr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
